// File: rtl/lcd_frame_gen.sv
// ILI9341 frame source: address-window preamble followed by one frame of RGB565
// test-pattern pixels, streamed as {dc, byte} under a valid/ready handshake.
module lcd_frame_gen #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [1:0]  pattern,
    input  logic [15:0] color,
    output logic [8:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned XW      = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned HDR_LEN = 11;
    localparam logic [15:0] H_LAST  = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST  = 16'(V_RES - 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [2:0] {IDLE, HDR, PIX_HI, PIX_LO, DONE} state_t;

    state_t        state;
    logic [3:0]    hdr_idx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    pat_q;
    logic [15:0]   col_q;
    logic [7:0]    pix_lo;

    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          last_pix;
    logic          xfer;
    logic [4:0]    xs;
    logic [5:0]    ys;
    logic [15:0]   pix_next;

    // CASET / PASET / RAMWR preamble, window bounds fixed at elaboration
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 9'h02A;
            4'd3:    return {1'b1, H_LAST[15:8]};
            4'd4:    return {1'b1, H_LAST[7:0]};
            4'd5:    return 9'h02B;
            4'd8:    return {1'b1, V_LAST[15:8]};
            4'd9:    return {1'b1, V_LAST[7:0]};
            4'd10:   return 9'h02C;
            default: return 9'h100;
        endcase
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Coordinates of the pixel about to be loaded, and its colour
    always_comb begin
        xfer     = out_valid && out_ready;
        last_pix = (x == X_LAST) && (y == Y_LAST);
        nx       = x;
        ny       = y;
        if (state == PIX_LO) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = y + YW'(1);
            end else begin
                nx = x + XW'(1);
            end
        end
        xs = 5'(nx >> 3);
        ys = 6'(ny >> 2);
        case (pat_q)
            2'd0:    pix_next = col_q;
            2'd1:    pix_next = bar_color(xs[4:2]);
            2'd2:    pix_next = (xs[1] ^ ys[2]) ? ~col_q : col_q;
            default: pix_next = {xs, ys, ~xs};
        endcase
    end

    // Sequencer; out_data is preloaded with the next byte on each transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            x          <= '0;
            y          <= '0;
            pat_q      <= '0;
            col_q      <= '0;
            pix_lo     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        pat_q     <= pattern;
                        col_q     <= color;
                        x         <= '0;
                        y         <= '0;
                        hdr_idx   <= '0;
                        out_data  <= hdr_byte(4'd0);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (hdr_idx == 4'(HDR_LEN - 1)) begin
                            out_data <= {1'b1, pix_next[15:8]};
                            pix_lo   <= pix_next[7:0];
                            state    <= PIX_HI;
                        end else begin
                            hdr_idx  <= hdr_idx + 4'd1;
                            out_data <= hdr_byte(hdr_idx + 4'd1);
                        end
                    end
                end
                PIX_HI: begin
                    if (xfer) begin
                        out_data <= {1'b1, pix_lo};
                        state    <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (xfer) begin
                        if (last_pix) begin
                            out_data   <= '0;
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            x        <= nx;
                            y        <= ny;
                            out_data <= {1'b1, pix_next[15:8]};
                            pix_lo   <= pix_next[7:0];
                            state    <= PIX_HI;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_frame_gen.md
# lcd_frame_gen

Upstream byte source for the LCD SPI path. On a frame request it produces the ILI9341 address-window preamble (CASET/PASET/RAMWR) and then a full frame of RGB565 pixels, two bytes per pixel, from a selectable test pattern. Output is a 9-bit `{dc, byte}` stream under a valid/ready handshake. The sequencer stage consumes it one byte per SPI transfer, with `dc` driven straight from bit 8.

## Interface
- `H_RES`, default 320: pixels per line; x counter range 0..H_RES-1.
- `V_RES`, default 240: lines per frame; y counter range 0..V_RES-1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `frame_start`  in  1  one-cycle request to begin a frame; ignored while `busy`.
- `pattern`  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 gradient; sampled on accepted `frame_start`.
- `color`  in  16  RGB565 base colour; sampled on accepted `frame_start`.
- `out_data`  out  9  bit 8 = dc (0 command, 1 data); bits 7:0 = byte.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  consumer accepts the byte this cycle.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last pixel byte transfers.

## Operation
- Transfer occurs on a cycle with `out_valid && out_ready`. While `out_valid && !out_ready`, `out_data` is held stable. `out_valid` never drops without a transfer.
- States: IDLE, HDR, PIX_HI, PIX_LO, DONE.
- IDLE: `busy`=0, `out_valid`=0. On `frame_start`, latch `pattern` and `color`, clear x, y and header index, then go to HDR.
- HDR emits 11 bytes in this order:
  - 0x02A (dc=0), then data bytes 0x00, 0x00, (H_RES-1)>>8, (H_RES-1)&0xFF.
  - 0x02B (dc=0), then data bytes 0x00, 0x00, (V_RES-1)>>8, (V_RES-1)&0xFF.
  - 0x02C (dc=0).
  - After the 11th transfer, go to PIX_HI.
- PIX_HI: emit {1, pix[15:8]}. On transfer, go to PIX_LO.
- PIX_LO: emit {1, pix[7:0]}. On transfer, advance the pixel:
  - If x == H_RES-1, set x = 0 and increment y; otherwise increment x.
  - If that was pixel (H_RES-1, V_RES-1), go to DONE; otherwise go to PIX_HI.
- DONE: assert `frame_done` for one cycle, then return to IDLE.
- Pixel value `pix` is a function of the current x, y and the latched inputs:
  - 0 solid: `color`.
  - 1 bars: table[(x>>5) & 7]. Table: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2 checkerboard: `color` if (x[4] ^ y[4]) == 0, else ~`color`.
  - 3 gradient: {x[7:3], y[7:2], ~x[7:3]}.
- The pixel value is computed combinationally from registered x/y, or registered in HI state. Either way, the HI and LO bytes come from the same 16-bit value.
- Counters are sized $clog2 of H_RES and V_RES. The header arithmetic is evaluated at elaboration.

## Timing
- Reset values: `out_valid`=0, `out_data`=9'h000, `busy`=0, `frame_done`=0. State is IDLE; x, y and header index are 0.
- `frame_start` sampled in cycle N gives `busy`=1 and `out_valid`=1 with `out_data`=0x02A in cycle N+1.
- With `out_ready` held high, one byte transfers per cycle with no bubbles. The total is 11 + 2·H_RES·V_RES bytes.
- The last transfer occurs in cycle M. In cycle M+1: `out_valid`=0, `frame_done`=1, `busy`=1. In cycle M+2: `busy`=0, `frame_done`=0.
- A new `frame_start` is accepted from cycle M+2 (IDLE).
- `frame_start` while busy (including DONE) is dropped, not queued.
- Changes to `pattern`/`color` mid-frame have no effect.
- `rst` asserted at any point immediately forces all outputs to their reset values. The partial frame is abandoned; no `frame_done` is produced.
- `out_ready` may toggle arbitrarily; the byte order is unaffected.

## Test plan
- H_RES=4, V_RES=2, pattern 0, color F800, `out_ready`=1:
  - Expect 27 bytes: 02A, 100, 100, 100, 103, 02B, 100, 100, 100, 101, 02C, then 1F8, 100 repeated 8 times.
  - Expect `frame_done` exactly one cycle after the last byte.
- Same frame with `out_ready` randomly deasserted 50%: identical byte sequence, `out_data` stable during every stall, no duplicated or lost bytes.
- Default 320×240, pattern 1:
  - Pixel x=0..31 → FFFF; x=32 → FFE0; x=256 → FFFF (table wraps).
  - Total byte count 153611.
- Pattern 2 with color 1234, H_RES=64, V_RES=32: pixel (16,0) = EDCB; pixel (16,16) = 1234.
- `frame_start` pulsed mid-frame and in the DONE cycle: ignored, single frame only. Pulse again two cycles after `frame_done`: new frame starts with 0x02A.
- Assert `rst` during PIX_LO of pixel 3: outputs reset asynchronously and no `frame_done`. After release, the next `frame_start` yields a full fresh header.
